// File: rtl/ring_out_arb_if.sv
// Link-side bundle for ring_out_arb: ring and PE request/grant pairs plus the outgoing link.
// master = arbiter side, slave = requesters and downstream link.
interface ring_out_arb_if #(
    parameter int DATA_W = 64
);
    logic              polarity;
    logic [1:0]        ring_vld;
    logic [DATA_W-1:0] ring_data_e;
    logic [DATA_W-1:0] ring_data_o;
    logic [1:0]        ring_gnt;
    logic [1:0]        pe_vld;
    logic [DATA_W-1:0] pe_data_e;
    logic [DATA_W-1:0] pe_data_o;
    logic [1:0]        pe_gnt;
    logic              out_so;
    logic [DATA_W-1:0] out_do;
    logic              out_ro;
    logic              proto_err;

    modport master (
        output polarity, ring_gnt, pe_gnt, out_so, out_do, proto_err,
        input  ring_vld, ring_data_e, ring_data_o, pe_vld, pe_data_e, pe_data_o, out_ro
    );

    modport slave (
        input  polarity, ring_gnt, pe_gnt, out_so, out_do, proto_err,
        output ring_vld, ring_data_e, ring_data_o, pe_vld, pe_data_e, pe_data_o, out_ro
    );
endinterface

// File: rtl/ring_out_arb.sv
// Output-port arbiter for one ring direction: ring pass-through vs PE injection, VC phased by polarity.
// Define RING_ARB_FAIR_EN for per-VC round-robin; otherwise ring has fixed priority over PE.
module ring_out_arb #(
    parameter int DATA_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    ring_out_arb_if.master  bus
);

    localparam logic LAST_RING = 1'b0;
    localparam logic LAST_PE   = 1'b1;

    function automatic logic [1:0] vc_onehot(input logic vc);
        return vc ? 2'b10 : 2'b01;
    endfunction

    logic              polarity_r;
    logic              out_so_r;
    logic [DATA_W-1:0] out_do_r;
    logic              proto_err_r;
    logic [1:0]        ring_vld_q_r;
    logic [1:0]        pe_vld_q_r;
    logic [1:0]        ring_gnt_q_r;
    logic [1:0]        pe_gnt_q_r;

    logic              ring_win_s;
    logic              pe_win_s;
    logic [1:0]        ring_gnt_s;
    logic [1:0]        pe_gnt_s;
    logic [DATA_W-1:0] win_data_s;
    logic              err_s;

`ifdef RING_ARB_FAIR_EN
    logic [1:0]        last_r;
`endif

    // Pick the winner among the two requesters on the currently eligible VC.
    always_comb begin
        ring_win_s = 1'b0;
        pe_win_s   = 1'b0;
        if (reset && bus.out_ro) begin
            if (bus.ring_vld[polarity_r] && bus.pe_vld[polarity_r]) begin
`ifdef RING_ARB_FAIR_EN
                if (last_r[polarity_r] == LAST_PE) begin
                    ring_win_s = 1'b1;
                end else begin
                    pe_win_s = 1'b1;
                end
`else
                ring_win_s = 1'b1;
`endif
            end else if (bus.ring_vld[polarity_r]) begin
                ring_win_s = 1'b1;
            end else if (bus.pe_vld[polarity_r]) begin
                pe_win_s = 1'b1;
            end else begin
                ring_win_s = 1'b0;
                pe_win_s   = 1'b0;
            end
        end else begin
            ring_win_s = 1'b0;
            pe_win_s   = 1'b0;
        end
    end

    // Grant vectors: a single bit on the eligible VC of the winner.
    always_comb begin
        ring_gnt_s = 2'b00;
        pe_gnt_s   = 2'b00;
        if (ring_win_s) begin
            ring_gnt_s = vc_onehot(polarity_r);
        end else if (pe_win_s) begin
            pe_gnt_s = vc_onehot(polarity_r);
        end else begin
            ring_gnt_s = 2'b00;
            pe_gnt_s   = 2'b00;
        end
    end

    // Select the winning packet for the link register.
    always_comb begin
        win_data_s = out_do_r;
        case ({ring_win_s, pe_win_s, polarity_r})
            3'b100:  win_data_s = bus.ring_data_e;
            3'b101:  win_data_s = bus.ring_data_o;
            3'b010:  win_data_s = bus.pe_data_e;
            3'b011:  win_data_s = bus.pe_data_o;
            default: win_data_s = out_do_r;
        endcase
    end

    // A valid that falls without having been granted the cycle before is a protocol violation.
    always_comb begin
        err_s = |((ring_vld_q_r & ~bus.ring_vld & ~ring_gnt_q_r) |
                  (pe_vld_q_r   & ~bus.pe_vld   & ~pe_gnt_q_r));
    end

    // Phase generator, link register, sticky error and request history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_r   <= 1'b0;
            out_so_r     <= 1'b0;
            out_do_r     <= {DATA_W{1'b0}};
            proto_err_r  <= 1'b0;
            ring_vld_q_r <= 2'b00;
            pe_vld_q_r   <= 2'b00;
            ring_gnt_q_r <= 2'b00;
            pe_gnt_q_r   <= 2'b00;
        end else begin
            polarity_r   <= ~polarity_r;
            out_so_r     <= ring_win_s | pe_win_s;
            if (ring_win_s || pe_win_s) begin
                out_do_r <= win_data_s;
            end else begin
                out_do_r <= out_do_r;
            end
            proto_err_r  <= proto_err_r | err_s;
            ring_vld_q_r <= bus.ring_vld;
            pe_vld_q_r   <= bus.pe_vld;
            ring_gnt_q_r <= ring_gnt_s;
            pe_gnt_q_r   <= pe_gnt_s;
        end
    end

`ifdef RING_ARB_FAIR_EN
    // Round-robin pointer for each VC advances only when both requesters contended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= {LAST_PE, LAST_PE};
        end else if (ring_win_s && bus.pe_vld[polarity_r]) begin
            last_r[polarity_r] <= LAST_RING;
        end else if (pe_win_s && bus.ring_vld[polarity_r]) begin
            last_r[polarity_r] <= LAST_PE;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    assign bus.polarity  = polarity_r;
    assign bus.ring_gnt  = ring_gnt_s;
    assign bus.pe_gnt    = pe_gnt_s;
    assign bus.out_so    = out_so_r;
    assign bus.out_do    = out_do_r;
    assign bus.proto_err = proto_err_r;

endmodule

// File: tb/tb_ring_out_arb.sv
// Directed bench for ring_out_arb: stimulus pushes expected link packets, a negedge monitor pops and compares.
module tb_ring_out_arb;

`ifdef RING_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc_cnt;
    logic mpol;
    logic [63:0] exp_q[$];

    ring_out_arb_if #(.DATA_W(64)) bus ();

    ring_out_arb #(.DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mpol = cyc_cnt[0];

    function automatic logic [1:0] oh(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        cyc_cnt++;
    endtask

    // Monitor: every link strobe must match the oldest expected packet.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_so !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pkt: got out_so=%b out_do=%0h expected no packet", bus.out_so, bus.out_do);
            end else begin
                chk("link_data", bus.out_do, exp_q.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic p;
        total = 0;
        bad = 0;
        cyc_cnt = 0;
        reset = 1'b1;
        bus.ring_vld = 2'b00;
        bus.pe_vld = 2'b00;
        bus.ring_data_e = 64'h0;
        bus.ring_data_o = 64'h0;
        bus.pe_data_e = 64'h0;
        bus.pe_data_o = 64'h0;
        bus.out_ro = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_pol", {63'h0, bus.polarity}, 64'h0);
        chk("rst_so", {63'h0, bus.out_so}, 64'h0);
        chk("rst_do", bus.out_do, 64'h0);
        chk("rst_gnt", {60'h0, bus.ring_gnt, bus.pe_gnt}, 64'h0);
        chk("rst_err", {63'h0, bus.proto_err}, 64'h0);

        // Release and watch the phase toggle.
        @(posedge clk);
        #2;
        reset = 1'b1;
        cyc_cnt = 0;
        #1;
        chk("rel_pol0", {63'h0, bus.polarity}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("rel_pol", {63'h0, bus.polarity}, {63'h0, mpol});
            chk("rel_idle", {61'h0, bus.out_so, bus.ring_gnt | bus.pe_gnt}, 64'h0);
            chk("rel_err", {63'h0, bus.proto_err}, 64'h0);
        end

        // Single PE packet on VC0.
        while (mpol != 1'b1) cyc();
        bus.pe_vld = 2'b01;
        bus.pe_data_e = 64'hA5;
        bus.out_ro = 1'b1;
        #1;
        chk("pe_wait", {62'h0, bus.pe_gnt}, 64'h0);
        cyc();
        #1;
        chk("pe_gnt", {62'h0, bus.pe_gnt}, 64'h1);
        chk("pe_ring0", {62'h0, bus.ring_gnt}, 64'h0);
        exp_q.push_back(64'hA5);
        cyc();
        bus.pe_vld = 2'b00;
        #1;
        chk("pe_pol", {63'h0, bus.polarity}, 64'h1);
        chk("pe_so", {63'h0, bus.out_so}, 64'h1);

        // Contention on VC1.
        while (mpol != 1'b1) cyc();
        bus.ring_vld = 2'b10;
        bus.pe_vld = 2'b10;
        bus.ring_data_o = 64'hB1;
        bus.pe_data_o = 64'hC1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if ((k < 5) && (!FAIR || (k % 2 == 0))) begin
                chk("cont_ring", {60'h0, bus.ring_gnt, bus.pe_gnt}, 64'h8);
                exp_q.push_back(64'hB1);
            end else begin
                chk("cont_pe", {60'h0, bus.ring_gnt, bus.pe_gnt}, 64'h2);
                exp_q.push_back(64'hC1);
            end
            cyc();
            if (k == 4) bus.ring_vld = 2'b00;
            if (k == 5) bus.pe_vld = 2'b00;
            #1;
            chk("cont_even_idle", {60'h0, bus.ring_gnt, bus.pe_gnt}, 64'h0);
            chk("cont_so", {63'h0, bus.out_so}, 64'h1);
            cyc();
        end
        #1;
        chk("cont_err", {63'h0, bus.proto_err}, 64'h0);

        // Alternating VCs, back-to-back link strobes.
        bus.ring_data_e = 64'h10;
        bus.ring_data_o = 64'h11;
        bus.ring_vld = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            p = mpol;
            chk("alt_gnt", {62'h0, bus.ring_gnt}, {62'h0, oh(p)});
            exp_q.push_back(p ? 64'h11 : 64'h10);
            if (i > 0) chk("alt_so", {63'h0, bus.out_so}, 64'h1);
            cyc();
            if (i >= 4) bus.ring_vld[p] = 1'b0;
            #1;
        end

        // Downstream back-pressure.
        cyc();
        bus.ring_data_e = 64'h20;
        bus.ring_data_o = 64'h21;
        bus.ring_vld = 2'b11;
        bus.out_ro = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_nogrant", {60'h0, bus.ring_gnt, bus.pe_gnt}, 64'h0);
            if (k > 0) chk("bp_so", {63'h0, bus.out_so}, 64'h0);
            cyc();
            #1;
        end
        bus.out_ro = 1'b1;
        #1;
        p = mpol;
        chk("bp_resume", {62'h0, bus.ring_gnt}, {62'h0, oh(p)});
        exp_q.push_back(p ? 64'h21 : 64'h20);
        cyc();
        bus.ring_vld[p] = 1'b0;
        #1;
        chk("bp_resume2", {62'h0, bus.ring_gnt}, {62'h0, oh(~p)});
        exp_q.push_back(p ? 64'h20 : 64'h21);
        cyc();
        bus.ring_vld = 2'b00;
        #1;

        // Protocol violation: PE VC1 withdrawn without a grant.
        cyc();
        bus.out_ro = 1'b0;
        bus.pe_vld = 2'b10;
        #1;
        chk("err_pre", {63'h0, bus.proto_err}, 64'h0);
        cyc();
        cyc();
        bus.pe_vld = 2'b00;
        #1;
        chk("err_not_yet", {63'h0, bus.proto_err}, 64'h0);
        cyc();
        #1;
        chk("err_set", {63'h0, bus.proto_err}, 64'h1);
        cyc();
        cyc();
        #1;
        chk("err_sticky", {63'h0, bus.proto_err}, 64'h1);

        // Async reset with a packet on the link: packet is lost.
        bus.out_ro = 1'b1;
        bus.ring_data_e = 64'h33;
        bus.ring_data_o = 64'h33;
        bus.ring_vld = oh(mpol);
        #1;
        chk("mid_gnt", {62'h0, bus.ring_gnt}, {62'h0, oh(mpol)});
        cyc();
        bus.ring_vld = 2'b00;
        #1;
        chk("mid_so", {63'h0, bus.out_so}, 64'h1);
        reset = 1'b0;
        bus.pe_vld = 2'b01;
        #1;
        chk("arst_so", {63'h0, bus.out_so}, 64'h0);
        chk("arst_pol", {63'h0, bus.polarity}, 64'h0);
        chk("arst_err", {63'h0, bus.proto_err}, 64'h0);
        chk("arst_gnt", {60'h0, bus.ring_gnt, bus.pe_gnt}, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("arst_hold_pol", {63'h0, bus.polarity}, 64'h0);
        bus.pe_vld = 2'b00;
        reset = 1'b1;
        cyc_cnt = 0;
        #1;
        chk("rel2_pol0", {63'h0, bus.polarity}, 64'h0);
        cyc();
        #1;
        chk("rel2_pol1", {63'h0, bus.polarity}, 64'h1);
        chk("rel2_err", {63'h0, bus.proto_err}, 64'h0);
        cyc();
        cyc();
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
